imem_loader: RTL and testbench

- Write-side counterpart of the single-cycle core's instruction memory: accepts a byte stream from a host, assembles little-endian 32-bit instruction words, and drives the memory write port.
- Holds the CPU (cpu_hold) for the whole load, then pulses done.
- Checks a trailing 8-bit additive checksum and flags errors.

---
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: assembles little-endian words,
// writes them from LOAD_BASE upward, holds the CPU meanwhile and verifies a trailing checksum.
module imem_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 32,
  parameter int LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int MAX_N = DEPTH - LOAD_BASE;
  localparam int WL_W  = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_BYTES,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q;
  logic [WL_W-1:0]   words_left_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [7:0]        chk_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_next;

  logic accept;
  logic n_too_big;
  logic n_zero;
  logic last_byte;

  logic in_ready_d;
  logic mem_we_d;
  logic cpu_hold_d;
  logic done_d;

  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  function automatic logic [DATA_W-1:0] lane_insert(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        lane,
                                                    input logic [7:0]        b);
    logic [DATA_W-1:0] w;
    w = word;
    w[8*lane +: 8] = b;
    return w;
  endfunction

  // in_ready is registered and mirrors the receiving states, so it is safe to qualify with.
  assign accept    = in_valid & in_ready;
  assign n_too_big = (32'(in_data) > 32'(MAX_N));
  assign n_zero    = (in_data == 8'd0);
  assign last_byte = (byte_cnt_q == 2'd3);
  assign asm_next  = lane_insert(asm_q, byte_cnt_q, in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (accept) begin
          if (n_too_big)   state_d = S_DONE;
          else if (n_zero) state_d = S_CHECK;
          else             state_d = S_BYTES;
        end
      end
      S_BYTES: begin
        if (accept && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = (words_left_q > WL_W'(1)) ? S_BYTES : S_CHECK;
      end
      S_CHECK: begin
        if (accept) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    in_ready_d = 1'b0;
    mem_we_d   = 1'b0;
    cpu_hold_d = 1'b1;
    done_d     = 1'b0;
    unique case (state_d)
      S_IDLE:  cpu_hold_d = 1'b0;
      S_COUNT: in_ready_d = 1'b1;
      S_BYTES: in_ready_d = 1'b1;
      S_WRITE: mem_we_d   = 1'b1;
      S_CHECK: in_ready_d = 1'b1;
      S_DONE:  done_d     = 1'b1;
      default: cpu_hold_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= in_ready_d;
      mem_we   <= mem_we_d;
      cpu_hold <= cpu_hold_d;
      done     <= done_d;
    end
  end

  // Datapath: counters, assembly register, checksum, write port and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      chk_q        <= '0;
      asm_q        <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err          <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            chk_q      <= '0;
            byte_cnt_q <= '0;
            err        <= 1'b0;
          end
        end
        S_COUNT: begin
          if (accept) begin
            if (n_too_big) begin
              err <= 1'b1;
            end else if (!n_zero) begin
              words_left_q <= WL_W'(in_data);
              word_idx_q   <= ADDR_W'(LOAD_BASE);
              byte_cnt_q   <= '0;
            end
          end
        end
        S_BYTES: begin
          if (accept) begin
            asm_q      <= asm_next;
            chk_q      <= chk_add(chk_q, in_data);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (last_byte) begin
              mem_addr  <= word_idx_q;
              mem_wdata <= asm_next;
            end
          end
        end
        S_WRITE: begin
          word_idx_q   <= word_idx_q + ADDR_W'(1);
          words_left_q <= words_left_q - WL_W'(1);
          byte_cnt_q   <= '0;
        end
        S_CHECK: begin
          if (accept) err <= (in_data != chk_q);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames with hand-computed words and checksums,
// oversize count, stalls, ignored start and mid-load reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  int          wr_cnt    = 0;
  int          done_cnt  = 0;
  int          we_ready  = 0;
  int          hold_drop = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  bit          in_load = 1'b0;

  imem_loader #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(32), .LOAD_BASE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr[wr_cnt[5:0]] = mem_addr;
      wr_data[wr_cnt[5:0]] = mem_wdata;
      wr_cnt = wr_cnt + 1;
      if (in_ready) we_ready = we_ready + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (in_load && !cpu_hold) hold_drop = hold_drop + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a rising edge.
  task automatic start_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_load = 1'b1;
    check_eq("hold_on_start", 32'(cpu_hold), 32'd1);
    check_eq("err_clr_on_start", 32'(err), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit taken;
    taken = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        taken = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!taken) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_load(input logic exp_err);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("err_at_done", 32'(err), 32'(exp_err));
    in_load = 1'b0;
    @(posedge clk); #1;
    check_eq("hold_off_after_done", 32'(cpu_hold), 32'd0);
    check_eq("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, {25'd0, in_ready, mem_we, cpu_hold, done, err, |mem_addr, |mem_wdata}, 32'd0);
  endtask

  int wb;
  int db;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check_outputs_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    check_eq("idle_ready", 32'(in_ready), 32'd0);

    // One word, good checksum.
    wb = wr_cnt; db = done_cnt;
    start_load();
    send_byte(8'h01);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'hA3);
    finish_load(1'b0);
    check_eq("t1_nwr", 32'(wr_cnt - wb), 32'd1);
    check_eq("t1_addr", wr_addr[wb[5:0]], 32'd0);
    check_eq("t1_data", wr_data[wb[5:0]], 32'h0010_0093);
    check_eq("t1_ndone", 32'(done_cnt - db), 32'd1);

    // Two words; sum 13+33+81+40 = 0x107 -> 0x07.
    wb = wr_cnt;
    start_load();
    send_byte(8'h02);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h81); send_byte(8'h00); send_byte(8'h40);
    send_byte(8'h07);
    finish_load(1'b0);
    check_eq("t2_nwr", 32'(wr_cnt - wb), 32'd2);
    check_eq("t2_addr0", wr_addr[wb[5:0]], 32'd0);
    check_eq("t2_data0", wr_data[wb[5:0]], 32'h0000_0013);
    check_eq("t2_addr1", wr_addr[6'(wb + 1)], 32'd1);
    check_eq("t2_data1", wr_data[6'(wb + 1)], 32'h4000_8133);
    check_eq("t2_ready_in_write", 32'(we_ready), 32'd0);

    // Bad checksum: write still happens, err sticks until next start.
    wb = wr_cnt;
    start_load();
    send_byte(8'h01);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h00);
    finish_load(1'b1);
    check_eq("t3_nwr", 32'(wr_cnt - wb), 32'd1);
    check_eq("t3_data", wr_data[wb[5:0]], 32'h0010_0093);
    idle(4);
    check_eq("t3_err_sticky", 32'(err), 32'd1);

    // Oversize count: no writes, err with done; next start clears err.
    wb = wr_cnt;
    start_load();
    send_byte(8'd33);
    finish_load(1'b1);
    check_eq("t4_nwr", 32'(wr_cnt - wb), 32'd0);
    check_eq("t4_err_sticky", 32'(err), 32'd1);

    // Stall between bytes 2 and 3 with a stray start pulse.
    wb = wr_cnt; db = done_cnt;
    start_load();
    send_byte(8'h01);
    send_byte(8'h93); send_byte(8'h00);
    idle(2);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(2);
    send_byte(8'h10); send_byte(8'h00);
    send_byte(8'hA3);
    finish_load(1'b0);
    check_eq("t5_nwr", 32'(wr_cnt - wb), 32'd1);
    check_eq("t5_data", wr_data[wb[5:0]], 32'h0010_0093);
    check_eq("t5_ndone", 32'(done_cnt - db), 32'd1);
    idle(2);
    check_eq("t5_stays_idle", 32'(in_ready), 32'd0);

    // Empty frame.
    wb = wr_cnt;
    start_load();
    send_byte(8'h00);
    send_byte(8'h00);
    finish_load(1'b0);
    check_eq("t5b_nwr", 32'(wr_cnt - wb), 32'd0);

    // Reset mid-load, then a fresh load; sum 78+56+34+12 = 0x114 -> 0x14.
    start_load();
    send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    in_load = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    wb = wr_cnt;
    start_load();
    send_byte(8'h01);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h14);
    finish_load(1'b0);
    check_eq("t6_nwr", 32'(wr_cnt - wb), 32'd1);
    check_eq("t6_addr", wr_addr[wb[5:0]], 32'd0);
    check_eq("t6_data", wr_data[wb[5:0]], 32'h1234_5678);

    check_eq("hold_never_dropped", 32'(hold_drop), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
